// File: rtl/stepper_pkg.sv
// Shared state type and default timing constants for the stepper ramp controller.
package stepper_pkg;

    localparam int unsigned CLK_HZ           = 50_000_000;
    localparam int unsigned DEF_START_PERIOD = 50_000;
    localparam int unsigned DEF_MIN_PERIOD   = 5_000;
    localparam int unsigned DEF_ACCEL_DEC    = 500;

    typedef enum logic [2:0] {
        StIdle,
        StAccel,
        StCruise,
        StDecel,
        StFinish
    } state_e;

    function automatic logic is_motion(input state_e s);
        return (s == StAccel) || (s == StCruise) || (s == StDecel);
    endfunction

endpackage

// File: rtl/step_timer.sv
// Loadable down-counter; o_zero flags the enabled cycle in which the count sits at zero.
module step_timer
    import stepper_pkg::*;
#(
    parameter int unsigned PERIOD_W = 24
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_load,
    input  logic [PERIOD_W-1:0] i_load_val,
    input  logic                i_en,
    output logic                o_zero
);

    logic [PERIOD_W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = i_en && (r_count == '0);

endmodule

// File: rtl/stepper_ramp_ctrl.sv
// Trapezoidal-ramp stepper motion controller: accepts a move, paces single-cycle
// step pulses from a down-counter and tracks signed position.
module stepper_ramp_ctrl
    import stepper_pkg::*;
#(
    parameter int unsigned PERIOD_W     = 24,
    parameter int unsigned START_PERIOD = DEF_START_PERIOD,
    parameter int unsigned MIN_PERIOD   = DEF_MIN_PERIOD,
    parameter int unsigned ACCEL_DEC    = DEF_ACCEL_DEC,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned POS_W        = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [CNT_W-1:0] i_cmd_steps,
    input  logic             i_cmd_dir,
    input  logic             i_abort,
    output logic             o_step,
    output logic             o_dir,
    output logic             o_busy,
    output logic             o_done,
    output logic [POS_W-1:0] o_position
);

    localparam logic [PERIOD_W-1:0] P_START = PERIOD_W'(START_PERIOD);
    localparam logic [PERIOD_W-1:0] P_MIN   = PERIOD_W'(MIN_PERIOD);
    localparam logic [PERIOD_W-1:0] P_DEC   = PERIOD_W'(ACCEL_DEC);

    state_e              r_state, w_state_s;
    logic                r_ready, r_dir, r_busy, r_done;
    logic [CNT_W-1:0]    r_rem, r_ramp, w_rem_s, w_ramp_s;
    logic [PERIOD_W-1:0] r_period, w_period_s, w_load_val;
    logic [PERIOD_W:0]   w_period_up, w_period_dn;
    logic [POS_W-1:0]    r_position;
    logic                w_accept, w_zero, w_load, w_to_finish;

    assign w_accept    = (r_state == StIdle) && r_ready && i_cmd_valid;
    assign w_period_up = {1'b0, r_period} + {1'b0, P_DEC};
    assign w_period_dn = {1'b0, r_period} - {1'b0, P_DEC};

    // Effect of a step pulse alone; the abort clamp is layered on afterwards.
    always_comb begin
        w_state_s  = r_state;
        w_rem_s    = r_rem;
        w_ramp_s   = r_ramp;
        w_period_s = r_period;
        if (w_zero) begin
            w_rem_s = r_rem - 1'b1;
            if (w_rem_s == '0) begin
                w_state_s = StFinish;
            end else if (w_rem_s <= r_ramp) begin
                w_state_s  = StDecel;
                w_ramp_s   = r_ramp - 1'b1;
                w_period_s = (w_period_up > {1'b0, P_START}) ? P_START
                                                             : w_period_up[PERIOD_W-1:0];
            end else if (r_state == StAccel) begin
                w_ramp_s   = r_ramp + 1'b1;
                w_period_s = (w_period_dn[PERIOD_W] || (w_period_dn[PERIOD_W-1:0] < P_MIN))
                             ? P_MIN : w_period_dn[PERIOD_W-1:0];
                if (w_period_s == P_MIN) begin
                    w_state_s = StCruise;
                end
            end
        end
    end

    // An abort with no ramp left to unwind finishes without further steps.
    assign w_to_finish = (w_state_s == StFinish) || (i_abort && (w_ramp_s == '0));
    assign w_load      = w_accept || w_zero;
    assign w_load_val  = w_accept ? (P_START - 1'b1) : (w_period_s - 1'b1);

    step_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_step_timer (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_en       (is_motion(r_state)),
        .o_zero     (w_zero)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_ready    <= 1'b0;
            r_dir      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rem      <= '0;
            r_ramp     <= '0;
            r_period   <= '0;
            r_position <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    r_ready <= 1'b1;
                    if (w_accept) begin
                        r_ready  <= 1'b0;
                        r_dir    <= i_cmd_dir;
                        r_rem    <= i_cmd_steps;
                        r_period <= P_START;
                        r_ramp   <= '0;
                        if (i_cmd_steps == '0) begin
                            r_state <= StFinish;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= StAccel;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                StFinish: begin
                    r_state <= StIdle;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_rem    <= w_rem_s;
                    r_ramp   <= w_ramp_s;
                    r_period <= w_period_s;
                    r_state  <= w_state_s;
                    if (w_zero) begin
                        r_position <= r_dir ? (r_position + 1'b1) : (r_position - 1'b1);
                    end
                    if (w_to_finish) begin
                        r_state <= StFinish;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (i_abort) begin
                        r_state <= StDecel;
                        r_rem   <= (w_rem_s < w_ramp_s) ? w_rem_s : w_ramp_s;
                    end
                end
            endcase
        end
    end

    assign o_cmd_ready = r_ready;
    assign o_step      = w_zero;
    assign o_dir       = r_dir;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_position  = r_position;

endmodule

// File: tb/tb_stepper_ramp_ctrl.sv
// Self-checking bench for stepper_ramp_ctrl: directed moves plus random moves checked
// against a per-step profile model.
module tb_stepper_ramp_ctrl;

    localparam int START = 20;
    localparam int MIN   = 8;
    localparam int DEC   = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_dir = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] cmd_steps = '0;
    logic        cmd_ready, step, dir, busy, done;
    logic [31:0] position;

    int total = 0;
    int bad = 0;
    int pos_exp = 0;
    int exp_iv[$];

    always #5 clk = ~clk;

    stepper_ramp_ctrl #(
        .PERIOD_W     (24),
        .START_PERIOD (START),
        .MIN_PERIOD   (MIN),
        .ACCEL_DEC    (DEC),
        .CNT_W        (16),
        .POS_W        (32)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_cmd_steps (cmd_steps),
        .i_cmd_dir   (cmd_dir),
        .i_abort     (abort),
        .o_step      (step),
        .o_dir       (dir),
        .o_busy      (busy),
        .o_done      (done),
        .o_position  (position)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Interval before each step; ab = step index after which abort is raised (0: before any).
    task automatic model_move(input int n, input int ab);
        int rem, ramp, per;
        bit cruising;
        exp_iv.delete();
        rem = n;
        ramp = 0;
        per = START;
        cruising = 1'b0;
        if (n == 0 || ab == 0) return;
        while (rem > 0) begin
            exp_iv.push_back(per);
            rem--;
            if (rem == 0) break;
            if (rem <= ramp) begin
                cruising = 1'b1;
                per = (per + DEC > START) ? START : per + DEC;
                ramp--;
            end else if (!cruising) begin
                per = (per - DEC < MIN) ? MIN : per - DEC;
                ramp++;
                if (per == MIN) cruising = 1'b1;
            end
            if (exp_iv.size() == ab) begin
                if (ramp == 0) break;
                rem = (rem < ramp) ? rem : ramp;
                cruising = 1'b1;
            end
        end
    endtask

    task automatic run_move(input string tag, input int n, input bit d, input int ab,
                            input int last_step_exp);
        int t, last, nst, t_done, t_done_exp, sum;
        model_move(n, ab);
        sum = 0;
        foreach (exp_iv[i]) sum += exp_iv[i];
        t_done_exp = (n == 0) ? 1 : (ab == 0) ? 2 : sum + 1;
        for (int i = 0; i < 100 && !cmd_ready; i++) tick();
        check({tag, ".ready"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_steps = 16'(n);
        cmd_dir = d;
        tick();
        cmd_valid = 1'b0;
        cmd_steps = 16'($urandom);
        cmd_dir = ~d;
        t = 1;
        last = 0;
        nst = 0;
        t_done = -1;
        if (n > 0 && ab == 0) abort = 1'b1;
        while (t_done < 0 && t < t_done_exp + 40) begin
            if (cmd_valid) check({tag, ".busy_ready"}, 32'(cmd_ready), 32'd0);
            if (busy) check({tag, ".dir"}, 32'(dir), 32'(d));
            if (step) begin
                if (nst < exp_iv.size()) check({tag, ".interval"}, 32'(t - last), 32'(exp_iv[nst]));
                else check({tag, ".extra_step"}, 32'(nst + 1), 32'(exp_iv.size()));
                last = t;
                nst++;
                pos_exp += d ? 1 : -1;
                if (nst == ab) abort = 1'b1;
            end
            if (done) begin
                t_done = t;
                check({tag, ".busy_at_done"}, 32'(busy), 32'd0);
            end
            tick();
            abort = 1'b0;
            t++;
            cmd_valid = (t < t_done_exp) && ($urandom_range(0, 3) == 0);
        end
        cmd_valid = 1'b0;
        check({tag, ".done_time"}, 32'(t_done), 32'(t_done_exp));
        check({tag, ".nsteps"}, 32'(nst), 32'(exp_iv.size()));
        check({tag, ".ready_after"}, 32'(cmd_ready), 32'd1);
        check({tag, ".done_pulse"}, 32'(done), 32'd0);
        check({tag, ".position"}, position, 32'(pos_exp));
        if (last_step_exp > 0) check({tag, ".last_step"}, 32'(last), 32'(last_step_exp));
    endtask

    initial begin
        int n, ab;
        bit d;
        #2;
        check("rst.step", 32'(step), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.dir", 32'(dir), 32'd0);
        check("rst.position", position, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rst.ready", 32'(cmd_ready), 32'd1);

        run_move("t1", 10, 1'b1, -1, 128);
        run_move("t2", 3, 1'b1, -1, 0);
        run_move("t3", 0, 1'b1, -1, 0);
        run_move("t4", 100, 1'b1, 5, 0);

        // Reset in the middle of cruise.
        for (int i = 0; i < 100 && !cmd_ready; i++) tick();
        cmd_valid = 1'b1;
        cmd_steps = 16'd100;
        cmd_dir = 1'b1;
        tick();
        cmd_valid = 1'b0;
        repeat (70) tick();
        cmd_valid = 1'b1;
        cmd_steps = 16'd7;
        check("t6.busy", 32'(busy), 32'd1);
        check("t6.ignored_ready", 32'(cmd_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6.step", 32'(step), 32'd0);
        check("t6.busy_rst", 32'(busy), 32'd0);
        check("t6.done", 32'(done), 32'd0);
        check("t6.position", position, 32'd0);
        cmd_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        pos_exp = 0;
        tick();
        check("t6.ready", 32'(cmd_ready), 32'd1);

        run_move("t5", 2, 1'b0, -1, 0);
        check("t5.neg_position", position, 32'hFFFF_FFFE);

        for (int k = 0; k < 12; k++) begin
            n = $urandom_range(0, 30);
            d = 1'($urandom_range(0, 1));
            ab = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n) : -1;
            run_move("rnd", n, d, ab, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
